mem_xfer_ctrl: RTL and testbench

- Memory-access sequencer between the multicycle processor's control FSM and the 32x16 data/instruction memory.
- Accepts single-word load/store and load-multiple/store-multiple (LM/SM) requests.
- Drives the memory's active-low read/write strobes, address and write data, and returns load data tagged with the destination register index.
- Runs on posedge clk so that all memory-side signals are stable at the memory's negedge sampling point.

---
 rtl/mem_xfer_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_xfer_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_xfer_ctrl.sv
// Memory-access sequencer for LW/SW/LM/SM: one word per XFER cycle, load data one cycle later, done one cycle after the last word.
// Optional MEM_WRAP_ERR_EN: an LM/SM step that would wrap address 31 -> 0 is dropped and the request ends with err=1.
module mem_xfer_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [IDX_W-1:0]  req_reg,
    input  logic [NREG-1:0]   req_mask,
    output logic [IDX_W-1:0]  reg_rd_idx,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              rsp_valid,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic [DATA_W-1:0] rsp_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_write_n,
    output logic              mem_read_n,
    input  logic [DATA_W-1:0] mem_out
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    localparam logic [1:0] OP_SM = 2'b11;

    state_t            state, state_nxt;
    logic [1:0]        op_q;
    logic [NREG-1:0]   mask_q;
    logic [IDX_W-1:0]  lw_reg_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept, is_load, last_word, wrap_stop;

    function automatic logic [IDX_W-1:0] first_set(input logic [NREG-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign req_ready   = proc_rst & (state == IDLE);
    assign accept      = req_valid & req_ready;
    assign is_load     = ~op_q[0];
    // mask_q holds only the words still to come after the current one
    assign last_word   = ~op_q[1] | (mask_q == '0);
    assign done        = (state == DONE);
    assign mem_read_n  = ~((state == XFER) & is_load);
    assign mem_write_n = ~((state == XFER) & ~is_load);
    assign mem_in      = (op_q == OP_SM) ? reg_rd_data : wdata_q;

`ifdef MEM_WRAP_ERR_EN
    logic err_q;

    assign wrap_stop = &mem_addr;
    assign err       = done & err_q;

    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if ((state == XFER) && !last_word && wrap_stop) begin
            err_q <= 1'b1;
        end
    end
`else
    assign wrap_stop = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_op[1] && (req_mask == '0)) state_nxt = DONE;
                    else                               state_nxt = XFER;
                end
            end
            XFER: begin
                if (last_word || wrap_stop) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            op_q       <= '0;
            mask_q     <= '0;
            lw_reg_q   <= '0;
            wdata_q    <= '0;
            mem_addr   <= '0;
            reg_rd_idx <= '0;
            rsp_valid  <= 1'b0;
            rsp_idx    <= '0;
            rsp_data   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= req_op;
                        lw_reg_q   <= req_reg;
                        wdata_q    <= req_wdata;
                        mem_addr   <= req_addr;
                        reg_rd_idx <= first_set(req_mask);
                        mask_q     <= req_mask & (req_mask - 1'b1);
                    end
                end
                XFER: begin
                    if (is_load) begin
                        rsp_valid <= 1'b1;
                        rsp_idx   <= op_q[1] ? reg_rd_idx : lw_reg_q;
                        rsp_data  <= mem_out;
                    end
                    if (!last_word && !wrap_stop) begin
                        mem_addr   <= mem_addr + 1'b1;
                        reg_rd_idx <= first_set(mask_q);
                        mask_q     <= mask_q & (mask_q - 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Self-checking bench for mem_xfer_ctrl: directed scenarios then random requests against a word-list reference model.
module tb_mem_xfer_ctrl;
    logic        clk = 1'b0;
    logic        proc_rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_addr;
    logic [15:0] req_wdata;
    logic [2:0]  req_reg;
    logic [7:0]  req_mask;
    logic [2:0]  reg_rd_idx;
    logic [15:0] reg_rd_data;
    logic        rsp_valid;
    logic [2:0]  rsp_idx;
    logic [15:0] rsp_data;
    logic        done;
    logic        err;
    logic [4:0]  mem_addr;
    logic [15:0] mem_in;
    logic        mem_write_n;
    logic        mem_read_n;
    logic [15:0] mem_out;

    logic [15:0] mem     [32];
    logic [15:0] exp_mem [32];
    logic [15:0] regs    [8];

    int checks = 0;
    int errors = 0;

    logic [1:0]  r_op;
    logic [4:0]  r_addr;
    logic [15:0] r_wd;
    logic [2:0]  r_rg;
    logic [7:0]  r_mask;

    always #5 clk = ~clk;

    assign mem_out     = mem[mem_addr];
    assign reg_rd_data = regs[reg_rd_idx];

    mem_xfer_ctrl dut (
        .clk(clk), .proc_rst(proc_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_reg(req_reg), .req_mask(req_mask),
        .reg_rd_idx(reg_rd_idx), .reg_rd_data(reg_rd_data),
        .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_data(rsp_data),
        .done(done), .err(err),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_write_n(mem_write_n),
        .mem_read_n(mem_read_n), .mem_out(mem_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_req_ready"}, req_ready, 0);
        chk({p, "_rsp_valid"}, rsp_valid, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_err"}, err, 0);
        chk({p, "_write_n"}, mem_write_n, 1);
        chk({p, "_read_n"}, mem_read_n, 1);
        chk({p, "_mem_addr"}, mem_addr, 0);
        chk({p, "_reg_rd_idx"}, reg_rd_idx, 0);
        chk({p, "_rsp_idx"}, rsp_idx, 0);
        chk({p, "_rsp_data"}, rsp_data, 0);
    endtask

    // Model: expand the request into its word list, then check the observed cycle trace against it.
    task automatic do_req(input logic [1:0] op, input logic [4:0] addr, input logic [15:0] wd,
                          input logic [2:0] rg, input logic [7:0] mask);
        int e_addr[$], e_wr[$], e_dat[$], e_ridx[$], e_rdat[$];
        int o_addr[$], o_wr[$], o_dat[$], o_acyc[$], o_ridx[$], o_rdat[$], o_rcyc[$];
        int idx[$];
        int a, cyc, done_cyc, waitc, d;
        logic e_err, o_err, both_low;

        if (!op[1]) idx.push_back(int'(rg));
        else for (int i = 0; i < 8; i++) if (mask[i]) idx.push_back(i);
        e_err = 1'b0;
        for (int k = 0; k < idx.size(); k++) begin
            a = int'(addr) + k;
`ifdef MEM_WRAP_ERR_EN
            if (a > 31) begin
                e_err = 1'b1;
                break;
            end
`endif
            a = a % 32;
            e_addr.push_back(a);
            if (op[0]) begin
                d = (op == 2'b01) ? int'(wd) : int'(regs[idx[k]]);
                e_wr.push_back(1);
                e_dat.push_back(d);
                exp_mem[a] = 16'(d);
            end else begin
                e_wr.push_back(0);
                e_dat.push_back(0);
                e_ridx.push_back(idx[k]);
                e_rdat.push_back(int'(exp_mem[a]));
            end
        end

        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_reg = rg; req_mask = mask;
        @(posedge clk);
        cyc = 0; done_cyc = -1; o_err = 1'b0; both_low = 1'b0;
        while (done_cyc < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) req_valid = 1'b0;
            if (!mem_read_n && !mem_write_n) both_low = 1'b1;
            if (!mem_read_n || !mem_write_n) begin
                o_addr.push_back(int'(mem_addr));
                o_wr.push_back(int'(!mem_write_n));
                o_dat.push_back(int'(mem_in));
                o_acyc.push_back(cyc);
                if (!mem_write_n) mem[mem_addr] = mem_in;
            end
            if (rsp_valid) begin
                o_ridx.push_back(int'(rsp_idx));
                o_rdat.push_back(int'(rsp_data));
                o_rcyc.push_back(cyc);
            end
            if (done) begin
                done_cyc = cyc;
                o_err = err;
            end
        end

        chk("done_seen", done_cyc >= 0, 1);
        chk("done_cycle", done_cyc, e_addr.size() + 1);
        chk("err_with_done", o_err, e_err);
        chk("strobe_exclusive", both_low, 0);
        chk("n_access", o_addr.size(), e_addr.size());
        for (int k = 0; k < e_addr.size() && k < o_addr.size(); k++) begin
            chk("acc_addr", o_addr[k], e_addr[k]);
            chk("acc_is_write", o_wr[k], e_wr[k]);
            chk("acc_cycle", o_acyc[k], k + 1);
            if (e_wr[k] == 1) chk("acc_wdata", o_dat[k], e_dat[k]);
        end
        chk("n_rsp", o_ridx.size(), e_ridx.size());
        for (int k = 0; k < e_ridx.size() && k < o_ridx.size(); k++) begin
            chk("rsp_idx", o_ridx[k], e_ridx[k]);
            chk("rsp_data", o_rdat[k], e_rdat[k]);
            chk("rsp_cycle", o_rcyc[k], k + 2);
        end
        @(negedge clk);
        chk("ready_after_done", req_ready, 1);
    endtask

    initial begin
        proc_rst = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0;
        req_wdata = '0; req_reg = '0; req_mask = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 16'($urandom);
            exp_mem[i] = mem[i];
        end
        for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        proc_rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", req_ready, 1);

        mem[5] = 16'h1234; exp_mem[5] = 16'h1234;
        do_req(2'b00, 5'd5, 16'h0, 3'd2, 8'h00);
        do_req(2'b01, 5'd7, 16'hBEEF, 3'd0, 8'h00);
        chk("sw_mem7", mem[7], 16'hBEEF);
        do_req(2'b00, 5'd7, 16'h0, 3'd4, 8'h00);
        do_req(2'b10, 5'd30, 16'h0, 3'd0, 8'b00001010);
        regs[0] = 16'h0011; regs[7] = 16'h0077;
        do_req(2'b11, 5'd31, 16'h0, 3'd0, 8'b10000001);
        chk("sm_mem31", mem[31], 16'h0011);
        do_req(2'b10, 5'd3, 16'h0, 3'd0, 8'h00);
        do_req(2'b11, 5'd12, 16'h0, 3'd0, 8'h00);

        // Abort an LM partway through with an asynchronous reset
        req_valid = 1'b1; req_op = 2'b10; req_addr = 5'd10; req_mask = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_lm_reading", mem_read_n, 0);
        #2 proc_rst = 1'b0;
        #1 check_reset_vals("midrst");
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
        end
        proc_rst = 1'b1;
        @(negedge clk);
        do_req(2'b00, 5'd5, 16'h0, 3'd6, 8'h00);

        for (int t = 0; t < 40; t++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_addr = 5'($urandom_range(0, 31));
            r_wd   = 16'($urandom);
            r_rg   = 3'($urandom_range(0, 7));
            r_mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)] = 16'($urandom);
            do_req(r_op, r_addr, r_wd, r_rg, r_mask);
        end

        for (int i = 0; i < 32; i++) chk("final_mem", mem[i], exp_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
